blk_9e957f: RTL and testbench

Upstream neighbour of the m_axi read-address register slice in the weight_s_sum mmap adapter. Accepts one read command (start address, length in beats) from the loader and issues a sequence of AXI4 AR bursts into the AR register slice. Each burst is capped at MAX_BURST beats and never crosses a 4 KB boundary. Its output is a valid/ready pair that stays stable under backpressure, so the register slice can be attached directly.

---
 rtl/blk_9e957f.sv | 149 ++++++++++++++
 tb/tb_blk_9e957f.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_9e957f.sv
// Splits one read command (start address, beat count) into AXI4 AR bursts of at most MAX_BURST beats that never cross 4 KB.
// Latency: command accept to first ar_valid is 1 cycle; final AR handshake to in_ready is 1 cycle; bursts issue back-to-back.
// Backpressure: ar_addr/ar_len hold while ar_valid & !ar_ready; in_ready stays low until the command is fully issued.
// Optional macro WEIGHT_S_SUM_MMAP_M_AXI_BURST_STATS_EN adds saturating burst_count/cmd_count outputs.
module blk_9e957f #(
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 32,
    parameter int DATA_BYTES = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [LEN_WIDTH-1:0]  in_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]            ar_len,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic                  busy
`ifdef WEIGHT_S_SUM_MMAP_M_AXI_BURST_STATS_EN
    ,
    output logic [31:0]           burst_count,
    output logic [31:0]           cmd_count
`endif
);

    localparam int OFF_BITS = $clog2(DATA_BYTES);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  remaining, remaining_nxt;
    logic [ADDR_WIDTH-1:0] ar_addr_nxt;
    logic [7:0]            ar_len_nxt;
    logic                  ar_valid_nxt, in_ready_nxt, busy_nxt;

    logic [ADDR_WIDTH-1:0] in_addr_al;
    logic [LEN_WIDTH-1:0]  in_beats;
    logic [LEN_WIDTH-1:0]  cur_beats;
    logic [ADDR_WIDTH-1:0] step_addr;
    logic [LEN_WIDTH-1:0]  step_rem;
    logic [LEN_WIDTH-1:0]  next_beats;
    logic                  ar_hs;

    // Beats for a burst starting at a bus-aligned offset within its 4 KB page.
    function automatic logic [LEN_WIDTH-1:0] calc_beats(input logic [11:0] off,
                                                        input logic [LEN_WIDTH-1:0] rem);
        logic [12:0]          to_4k;
        logic [LEN_WIDTH-1:0] b;
        to_4k = (13'h1000 - {1'b0, off}) >> OFF_BITS;
        b = rem;
        if (b > LEN_WIDTH'(MAX_BURST)) b = LEN_WIDTH'(MAX_BURST);
        if (b > LEN_WIDTH'(to_4k))     b = LEN_WIDTH'(to_4k);
        return b;
    endfunction

    // ar_addr doubles as the current burst address; the following burst is precomputed
    // from it so the next AR beat can be registered in the same cycle as the handshake.
    assign in_addr_al = in_addr & ~ADDR_WIDTH'(DATA_BYTES - 1);
    assign in_beats   = calc_beats(in_addr_al[11:0], in_len);
    assign cur_beats  = calc_beats(ar_addr[11:0], remaining);
    assign step_addr  = ar_addr + (ADDR_WIDTH'(cur_beats) << OFF_BITS);
    assign step_rem   = remaining - cur_beats;
    assign next_beats = calc_beats(step_addr[11:0], step_rem);
    assign ar_hs      = ar_valid & ar_ready;

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        ar_addr_nxt   = ar_addr;
        ar_len_nxt    = ar_len;
        ar_valid_nxt  = ar_valid;
        in_ready_nxt  = in_ready;
        busy_nxt      = busy;
        case (state)
            IDLE: begin
                in_ready_nxt = 1'b1;
                ar_valid_nxt = 1'b0;
                busy_nxt     = 1'b0;
                if (in_valid && in_ready) begin
                    remaining_nxt = in_len;
                    ar_addr_nxt   = in_addr_al;
                    if (in_len != '0) begin
                        state_nxt    = ISSUE;
                        in_ready_nxt = 1'b0;
                        busy_nxt     = 1'b1;
                        ar_valid_nxt = 1'b1;
                        ar_len_nxt   = 8'(in_beats - LEN_WIDTH'(1));
                    end
                end
            end
            ISSUE: begin
                if (ar_hs) begin
                    ar_addr_nxt   = step_addr;
                    remaining_nxt = step_rem;
                    if (step_rem == '0) begin
                        state_nxt    = IDLE;
                        ar_valid_nxt = 1'b0;
                        busy_nxt     = 1'b0;
                        in_ready_nxt = 1'b1;
                    end else begin
                        ar_len_nxt = 8'(next_beats - LEN_WIDTH'(1));
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            ar_addr   <= '0;
            ar_len    <= '0;
            ar_valid  <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            ar_addr   <= ar_addr_nxt;
            ar_len    <= ar_len_nxt;
            ar_valid  <= ar_valid_nxt;
            in_ready  <= in_ready_nxt;
            busy      <= busy_nxt;
        end
    end

`ifdef WEIGHT_S_SUM_MMAP_M_AXI_BURST_STATS_EN
    // Saturating counts of issued bursts and accepted non-empty commands.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_count <= '0;
            cmd_count   <= '0;
        end else begin
            if (ar_hs && burst_count != 32'hFFFF_FFFF)
                burst_count <= burst_count + 32'd1;
            if (state == IDLE && in_valid && in_ready && in_len != '0 && cmd_count != 32'hFFFF_FFFF)
                cmd_count <= cmd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_blk_9e957f.sv
// Randomised and directed bench for the AR burst splitter.
// Expected bursts come from an arithmetic model of the 4 KB / MAX_BURST split rules.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_blk_9e957f;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_addr;
    logic [31:0] in_len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic        ar_valid;
    logic        ar_ready;
    logic        busy;
`ifdef WEIGHT_S_SUM_MMAP_M_AXI_BURST_STATS_EN
    logic [31:0] burst_count;
    logic [31:0] cmd_count;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } burst_t;

    burst_t exp_q[$];
    burst_t got_q[$];

    always #5 clk = ~clk;

    blk_9e957f dut (
        .clk      (clk),
        .reset    (reset),
        .in_addr  (in_addr),
        .in_len   (in_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ar_addr  (ar_addr),
        .ar_len   (ar_len),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .busy     (busy)
`ifdef WEIGHT_S_SUM_MMAP_M_AXI_BURST_STATS_EN
        ,
        .burst_count (burst_count),
        .cmd_count   (cmd_count)
`endif
    );

    // Reference: walk the command in bytes, cutting at 16 beats and at each 4 KB page end.
    task automatic model(input logic [63:0] addr, input logic [31:0] len);
        logic [63:0]     a;
        longint unsigned rem;
        longint unsigned room;
        longint unsigned b;
        burst_t          e;
        exp_q.delete();
        a   = addr - (addr % 64);
        rem = len;
        while (rem > 0) begin
            room = (4096 - (a % 4096)) / 64;
            b = rem;
            if (b > 16) b = 16;
            if (b > room) b = room;
            e.addr = a;
            e.len  = 8'(b - 1);
            exp_q.push_back(e);
            a   = a + 64'(b * 64);
            rem = rem - b;
        end
    endtask

    function automatic bit queues_equal();
        if (got_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Present one command for a single accepted cycle; caller is at a falling edge.
    task automatic send_cmd(input logic [63:0] a, input logic [31:0] l);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_cmd_timeout in_ready=%b required 1", in_ready);
        end
        in_addr  = a;
        in_len   = l;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Drive ar_ready (0: always, 1: 5 low then toggle, 2: random) and record handshakes until in_ready returns.
    task automatic collect(input int mode, output int n_cyc, output int last_hs,
                           output bit stable_ok, output bit done);
        bit     stall;
        bit     r;
        burst_t prev;
        burst_t cur;
        got_q.delete();
        stable_ok = 1'b1;
        done      = 1'b0;
        last_hs   = -1;
        n_cyc     = -1;
        stall     = 1'b0;
        prev      = '0;
        for (int c = 0; c < 2000; c++) begin
            if (in_ready === 1'b1) begin
                done  = 1'b1;
                n_cyc = c;
                break;
            end
            cur.addr = ar_addr;
            cur.len  = ar_len;
            if (stall && !(ar_valid === 1'b1 && cur === prev)) stable_ok = 1'b0;
            case (mode)
                0:       r = 1'b1;
                1:       r = (c < 5) ? 1'b0 : c[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            ar_ready = r;
            if (ar_valid === 1'b1 && r) begin
                got_q.push_back(cur);
                last_hs = c;
            end
            stall = (ar_valid === 1'b1) && !r;
            prev  = cur;
            @(negedge clk);
        end
        ar_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_len   = '0;
        ar_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ar_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl ar_valid=%b busy=%b in_ready=%b required 0 0 0", ar_valid, busy, in_ready);
        end
        checks++;
        if (ar_addr !== 64'h0 || ar_len !== 8'h0) begin
            failures++;
            $display("FAIL reset_data ar_addr=%h ar_len=%h required 0 0", ar_addr, ar_len);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || ar_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b busy=%b ar_valid=%b required 1 0 0", in_ready, busy, ar_valid);
        end
    endtask

    task automatic test_split();
        int n_cyc, last_hs;
        bit stable_ok, done;
        model(64'h0, 32'd40);
        send_cmd(64'h0, 32'd40);
        checks++;
        if (ar_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL split_first_latency ar_valid=%b busy=%b in_ready=%b required 1 1 0", ar_valid, busy, in_ready);
        end
        collect(0, n_cyc, last_hs, stable_ok, done);
        checks++;
        if (!done || queues_equal() !== 1'b1) begin
            failures++;
            $display("FAIL split_bursts got=%0d bursts required %0d (0x0/15,0x400/15,0x800/7)", got_q.size(), exp_q.size());
        end
        checks++;
        if (last_hs !== 2 || n_cyc !== 3) begin
            failures++;
            $display("FAIL split_b2b last_hs=%0d ready_at=%0d required 2 3", last_hs, n_cyc);
        end
        checks++;
        if (busy !== 1'b0 || ar_valid !== 1'b0) begin
            failures++;
            $display("FAIL split_done busy=%b ar_valid=%b required 0 0", busy, ar_valid);
        end
    endtask

    task automatic test_4k();
        int n_cyc, last_hs;
        bit stable_ok, done;
        model(64'hF80, 32'd8);
        send_cmd(64'hF80, 32'd8);
        collect(0, n_cyc, last_hs, stable_ok, done);
        checks++;
        if (!done || queues_equal() !== 1'b1) begin
            failures++;
            $display("FAIL boundary_4k got=%0d bursts first=%h/%0d required 0xf80/1,0x1000/5",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].addr : 64'hx, (got_q.size() > 0) ? got_q[0].len : 8'hx);
        end
    endtask

    task automatic test_zero_len();
        bit quiet;
        send_cmd(64'h40, 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ar_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL zero_len ar_valid=%b in_ready=%b busy=%b required 0 1 0", ar_valid, in_ready, busy);
        end
    endtask

    task automatic test_unaligned();
        int n_cyc, last_hs;
        bit stable_ok, done;
        model(64'h1007, 32'd1);
        send_cmd(64'h1007, 32'd1);
        collect(0, n_cyc, last_hs, stable_ok, done);
        checks++;
        if (!done || queues_equal() !== 1'b1) begin
            failures++;
            $display("FAIL unaligned got=%0d bursts first=%h required 1 burst 0x1000/0",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].addr : 64'hx);
        end
    endtask

    task automatic test_backpressure();
        int n_cyc, last_hs;
        bit stable_ok, done;
        model(64'h0, 32'd20);
        send_cmd(64'h0, 32'd20);
        collect(1, n_cyc, last_hs, stable_ok, done);
        checks++;
        if (stable_ok !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_stable stable=%b required 1", stable_ok);
        end
        checks++;
        if (!done || queues_equal() !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_bursts got=%0d required %0d (0x0/15,0x400/3)", got_q.size(), exp_q.size());
        end
        checks++;
        if (n_cyc !== last_hs + 1) begin
            failures++;
            $display("FAIL backpressure_ready_latency ready_at=%0d required %0d", n_cyc, last_hs + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n_cyc, last_hs;
        bit stable_ok, done;
        send_cmd(64'h0, 32'd40);
        ar_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ar_valid !== 1'b1 || ar_addr !== 64'h400 || ar_len !== 8'd15) begin
            failures++;
            $display("FAIL reset_mid_second ar_valid=%b ar_addr=%h ar_len=%0d required 1 400 15", ar_valid, ar_addr, ar_len);
        end
        reset = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        checks++;
        if (ar_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_abort ar_valid=%b in_ready=%b busy=%b required 0 0 0", ar_valid, in_ready, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || ar_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release in_ready=%b ar_valid=%b required 1 0", in_ready, ar_valid);
        end
        model(64'h2000, 32'd1);
        send_cmd(64'h2000, 32'd1);
        collect(0, n_cyc, last_hs, stable_ok, done);
        checks++;
        if (!done || queues_equal() !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_new got=%0d bursts first=%h required 1 burst 0x2000/0",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].addr : 64'hx);
        end
    endtask

    task automatic test_random();
        int          n_cyc, last_hs;
        bit          stable_ok, done;
        logic [63:0] a;
        logic [31:0] l;
        for (int it = 0; it < 25; it++) begin
            a = {$urandom, $urandom};
            if (it % 5 == 0) a[63:16] = '1;
            l = 32'($urandom_range(1, 70));
            model(a, l);
            send_cmd(a, l);
            collect(2, n_cyc, last_hs, stable_ok, done);
            checks++;
            if (!done || queues_equal() !== 1'b1 || stable_ok !== 1'b1 || n_cyc !== last_hs + 1) begin
                failures++;
                $display("FAIL random_cmd it=%0d addr=%h len=%0d got=%0d bursts stable=%b ready_at=%0d required %0d bursts stable=1 ready_at=%0d",
                         it, a, l, got_q.size(), stable_ok, n_cyc, exp_q.size(), last_hs + 1);
            end
        end
    endtask

`ifdef WEIGHT_S_SUM_MMAP_M_AXI_BURST_STATS_EN
    task automatic test_stats();
        int n_cyc, last_hs;
        bit stable_ok, done;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_cmd(64'h0, 32'd40);
        collect(0, n_cyc, last_hs, stable_ok, done);
        send_cmd(64'h0, 32'd0);
        @(negedge clk);
        send_cmd(64'hF80, 32'd8);
        collect(2, n_cyc, last_hs, stable_ok, done);
        checks++;
        if (burst_count !== 32'd5 || cmd_count !== 32'd2) begin
            failures++;
            $display("FAIL stats burst_count=%0d cmd_count=%0d required 5 2", burst_count, cmd_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_split();
        test_4k();
        test_zero_len();
        test_unaligned();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef WEIGHT_S_SUM_MMAP_M_AXI_BURST_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
